// File: rtl/tl_rx_write_handler_tlp_sequencer_pkg.sv
// Shared types and field positions for the RX write-handler TLP sequencer.
// No logic of its own. Latency and backpressure do not apply.
package tl_rx_write_handler_tlp_sequencer_pkg;

  localparam int DW         = 32;
  localparam int BEAT_DW    = 8;
  localparam int DATA_WIDTH = BEAT_DW * DW;
  localparam int LEN_W      = 3;
  localparam int CNT_W      = 11;

  // Bit positions inside the beat. DW0 occupies the top 32 bits of the bus.
  localparam int DW0_LSB      = DATA_WIDTH - DW;
  localparam int FMT_4DW_POS  = DW0_LSB + 29;
  localparam int FMT_DATA_POS = DW0_LSB + 30;
  localparam int TD_POS       = DW0_LSB + 15;
  localparam int LEN_MSB      = DW0_LSB + 9;
  localparam int LEN_LSB      = DW0_LSB;

  localparam logic [LEN_W-1:0] DW_1 = 3'd0;
  localparam logic [LEN_W-1:0] DW_2 = 3'd1;
  localparam logic [LEN_W-1:0] DW_3 = 3'd2;
  localparam logic [LEN_W-1:0] DW_4 = 3'd3;
  localparam logic [LEN_W-1:0] DW_5 = 3'd4;
  localparam logic [LEN_W-1:0] DW_6 = 3'd5;
  localparam logic [LEN_W-1:0] DW_7 = 3'd6;
  localparam logic [LEN_W-1:0] DW_8 = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } seq_state_e;

  // DW count to valid-DW code. A zero count maps to DW_1; the checker
  // ignores the code in that case because its enable is low.
  function automatic logic [LEN_W-1:0] dw_code(input logic [3:0] n);
    logic [LEN_W-1:0] code;
    case (n)
      4'd2:    code = DW_2;
      4'd3:    code = DW_3;
      4'd4:    code = DW_4;
      4'd5:    code = DW_5;
      4'd6:    code = DW_6;
      4'd7:    code = DW_7;
      4'd8:    code = DW_8;
      default: code = DW_1;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tl_rx_hdr_decode.sv
// Turns the Fmt, Length and TD fields of DW0 into the TLP's total DW count.
// Purely combinational. Latency and backpressure do not apply.
module tl_rx_hdr_decode
  import tl_rx_write_handler_tlp_sequencer_pkg::*;
(
  input  logic             fmt_4dw,
  input  logic             fmt_data,
  input  logic [9:0]       len,
  input  logic             td_bit,
  output logic [CNT_W-1:0] total,
  output logic             td
);

  logic [CNT_W-1:0] hdr_dw;
  logic [CNT_W-1:0] pay_dw;

  always_comb begin
    hdr_dw = fmt_4dw ? CNT_W'(4) : CNT_W'(3);
    pay_dw = '0;
    if (fmt_data) begin
      // A Length field of zero encodes the maximum payload.
      pay_dw = (len == 10'd0) ? CNT_W'(1024) : CNT_W'(len);
    end
    td    = td_bit;
    total = hdr_dw + pay_dw + CNT_W'(td_bit);
  end

endmodule

// File: rtl/tl_rx_write_handler_tlp_sequencer.sv
// Parses TLP beats and drives per-beat ECRC controls through one register slice. Latency is 1 cycle.
// Under backpressure o_ready = ~o_valid | i_out_ready, and the held beat together with its strobes is not repeated.
module tl_rx_write_handler_tlp_sequencer
  import tl_rx_write_handler_tlp_sequencer_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_n_rst,
  input  logic                  i_cfg_ecrc_chk_en,
  input  logic                  i_valid,
  input  logic                  i_sop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic [3:0]            o_dw_cnt,
  output logic [LEN_W-1:0]      o_ecrc_len,
  output logic                  o_ecrc_en,
  output logic                  o_ecrc_done,
  output logic                  o_ecrc_n_clr,
  output logic                  o_hdr_blk_EP,
  output logic                  o_malformed
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             td_q, td_d;
  logic             armed_q;

  logic             acc, out_hs;
  logic             start, drop, abort, fwd;
  logic [CNT_W-1:0] dec_total, cur_rem;
  logic             dec_td, cur_td;
  logic [3:0]       beat_n, covered;
  logic             beat_last;

  tl_rx_hdr_decode u_hdr_decode (
    .fmt_4dw  (i_data[FMT_4DW_POS]),
    .fmt_data (i_data[FMT_DATA_POS]),
    .len      (i_data[LEN_MSB:LEN_LSB]),
    .td_bit   (i_data[TD_POS]),
    .total    (dec_total),
    .td       (dec_td)
  );

  assign o_ready = ~o_valid | i_out_ready;
  assign acc     = i_valid & o_ready;
  assign out_hs  = o_valid & i_out_ready;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    td_d      = td_q;
    start     = acc & i_sop;
    drop      = acc & ~i_sop & (state_q == ST_IDLE);
    abort     = start & (state_q == ST_BODY);
    fwd       = acc & ~drop;
    // A sop beat restarts decode even mid-TLP, so the fresh header wins.
    cur_rem   = start ? dec_total : rem_q;
    cur_td    = start ? dec_td : td_q;
    beat_last = (cur_rem <= CNT_W'(BEAT_DW));
    beat_n    = beat_last ? cur_rem[3:0] : 4'(BEAT_DW);
    covered   = beat_n;
    if (beat_last && cur_td && (beat_n != 4'd0)) begin
      covered = beat_n - 4'd1;
    end
    if (fwd) begin
      td_d    = cur_td;
      rem_d   = beat_last ? '0 : (cur_rem - CNT_W'(BEAT_DW));
      state_d = beat_last ? ST_IDLE : ST_BODY;
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      td_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      td_q    <= td_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      armed_q      <= 1'b0;
      o_malformed  <= 1'b0;
      o_ecrc_n_clr <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_last       <= 1'b0;
      o_dw_cnt     <= '0;
      o_ecrc_len   <= '0;
      o_ecrc_en    <= 1'b0;
      o_ecrc_done  <= 1'b0;
      o_hdr_blk_EP <= 1'b0;
    end else begin
      armed_q      <= armed_q | acc;
      o_malformed  <= drop | abort;
      // Seed reload lasts exactly one cycle after a consumed done beat or an aborted TLP.
      o_ecrc_n_clr <= (armed_q | acc) & ~abort & ~(out_hs & o_ecrc_done);
      if (fwd) begin
        o_valid      <= 1'b1;
        o_data       <= i_data;
        o_last       <= beat_last;
        o_dw_cnt     <= covered;
        o_ecrc_len   <= dw_code(covered);
        o_ecrc_en    <= cur_td & i_cfg_ecrc_chk_en & (covered != 4'd0);
        o_ecrc_done  <= beat_last & cur_td & i_cfg_ecrc_chk_en;
        o_hdr_blk_EP <= start;
      end else if (drop | out_hs) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tl_rx_write_handler_tlp_sequencer.sv
// Directed bench for the TLP sequencer: a beat-level model expands each TLP into expected output beats.
// A negedge compare process checks every valid output cycle, and literal expectations pin the model.
module tb_tl_rx_write_handler_tlp_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         chk_en = 1'b0;
  logic         in_vld = 1'b0;
  logic         in_sop = 1'b0;
  logic [255:0] in_dat = '0;
  logic         out_rdy = 1'b1;
  logic         o_ready, o_valid, o_last, o_ecrc_en, o_ecrc_done, o_ecrc_n_clr, o_hdr_blk_EP, o_malformed;
  logic [255:0] o_data;
  logic [3:0]   o_dw_cnt;
  logic [2:0]   o_ecrc_len;

  always #5 clk = ~clk;

  tl_rx_write_handler_tlp_sequencer dut (
    .i_clk             (clk),
    .i_n_rst           (rst_n),
    .i_cfg_ecrc_chk_en (chk_en),
    .i_valid           (in_vld),
    .i_sop             (in_sop),
    .i_data            (in_dat),
    .o_ready           (o_ready),
    .o_valid           (o_valid),
    .i_out_ready       (out_rdy),
    .o_data            (o_data),
    .o_last            (o_last),
    .o_dw_cnt          (o_dw_cnt),
    .o_ecrc_len        (o_ecrc_len),
    .o_ecrc_en         (o_ecrc_en),
    .o_ecrc_done       (o_ecrc_done),
    .o_ecrc_n_clr      (o_ecrc_n_clr),
    .o_hdr_blk_EP      (o_hdr_blk_EP),
    .o_malformed       (o_malformed)
  );

  typedef struct packed {
    logic [255:0] data;
    logic         last;
    logic [3:0]   dw;
    logic [2:0]   len;
    logic         en;
    logic         done;
    logic         hdr;
  } beat_t;

  beat_t exp_q[$];
  beat_t seen_q[$];
  int    total = 0;
  int    bad = 0;
  int    exp_malf = 0;
  int    malf_cnt = 0;
  int    exp_nclr_low = 0;
  int    nclr_low_cnt = 0;
  logic  tb_armed = 1'b0;

  task automatic check(input string name, input logic [271:0] act, input logic [271:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Whenever a beat is presented it must match the head of the expected queue.
  // The head is retired only when the beat is handed off.
  always @(negedge clk) begin
    beat_t e;
    beat_t a;
    if (rst_n) begin
      if (o_malformed) malf_cnt++;
      if (tb_armed && !o_ecrc_n_clr) nclr_low_cnt++;
      check("ready_rule", 272'(o_ready), 272'(!o_valid || out_rdy));
      if (o_valid) begin
        a = {o_data, o_last, o_dw_cnt, o_ecrc_len, o_ecrc_en, o_ecrc_done, o_hdr_blk_EP};
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 272'(1), 272'(0));
        end else begin
          e = exp_q[0];
          check("out_beat", 272'(a), 272'(e));
          if (out_rdy) begin
            void'(exp_q.pop_front());
            seen_q.push_back(a);
            if (e.done) exp_nclr_low++;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic sop, input logic [255:0] d);
    int   guard;
    logic accepted;
    guard = 0;
    accepted = 1'b0;
    in_vld = 1'b1;
    in_sop = sop;
    in_dat = d;
    while (!accepted) begin
      @(negedge clk);
      accepted = o_ready;
      @(posedge clk);
      guard++;
      if (!accepted && guard > 100) begin
        check("accept_timeout", 272'(1), 272'(0));
        break;
      end
    end
    #1;
    in_vld = 1'b0;
    in_sop = 1'b0;
    tb_armed = 1'b1;
  endtask

  // Expand one TLP into the beats the design must emit.
  // Only the first nsend beats are sent, and output is stalled for five cycles after beat stall_at.
  task automatic send_tlp(input logic [2:0] fmt, input int len, input logic td, input int nsend, input int stall_at);
    int           hdr, pay, tot, nb, dws, cov;
    logic [9:0]   len_f;
    logic [255:0] d;
    beat_t        e;
    hdr   = fmt[0] ? 4 : 3;
    pay   = fmt[1] ? ((len == 0) ? 1024 : len) : 0;
    tot   = hdr + pay + (td ? 1 : 0);
    nb    = (tot + 7) / 8;
    len_f = 10'(len);
    for (int b = 0; b < nb && b < nsend; b++) begin
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      if (b == 0) begin
        d[255:253] = fmt;
        d[239]     = td;
        d[233:224] = len_f;
      end
      dws    = (tot - 8 * b < 8) ? (tot - 8 * b) : 8;
      e.last = (b == nb - 1);
      cov    = dws - ((e.last && td) ? 1 : 0);
      e.data = d;
      e.dw   = 4'(cov);
      e.len  = (cov == 0) ? 3'd0 : 3'(cov - 1);
      e.en   = td && chk_en && (cov != 0);
      e.done = e.last && td && chk_en;
      e.hdr  = (b == 0);
      exp_q.push_back(e);
      send_beat(b == 0, d);
      if (b == stall_at) begin
        out_rdy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_ready_low", 272'(o_ready), 272'(0));
          @(posedge clk);
        end
        #1;
        out_rdy = 1'b1;
      end
    end
  endtask

  task automatic check_reset_values();
    @(negedge clk);
    check("rst_valid", 272'(o_valid), 272'(0));
    check("rst_ready", 272'(o_ready), 272'(1));
    check("rst_last", 272'(o_last), 272'(0));
    check("rst_dw_cnt", 272'(o_dw_cnt), 272'(0));
    check("rst_len", 272'(o_ecrc_len), 272'(0));
    check("rst_en", 272'(o_ecrc_en), 272'(0));
    check("rst_done", 272'(o_ecrc_done), 272'(0));
    check("rst_n_clr", 272'(o_ecrc_n_clr), 272'(0));
    check("rst_hdr_ep", 272'(o_hdr_blk_EP), 272'(0));
    check("rst_malformed", 272'(o_malformed), 272'(0));
    check("rst_data", 272'(o_data), 272'(0));
  endtask

  initial begin
    int en_cnt, done_cnt, last_cnt;
    rst_n = 1'b0;
    idle(3);
    check_reset_values();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    check("idle_n_clr_before_beat", 272'(o_ecrc_n_clr), 272'(0));

    // 3DW MWr Len=4 with digest: fits exactly one beat
    chk_en = 1'b1;
    seen_q.delete();
    send_tlp(3'b010, 4, 1'b1, 99, -1);
    idle(4);
    check("t1_beats", 272'(seen_q.size()), 272'(1));
    if (seen_q.size() == 1) begin
      check("t1_dw_cnt", 272'(seen_q[0].dw), 272'(7));
      check("t1_len", 272'(seen_q[0].len), 272'(6));
      check("t1_flags", 272'({seen_q[0].en, seen_q[0].done, seen_q[0].last, seen_q[0].hdr}), 272'(4'b1111));
    end

    // 4DW MWr Len=4 with digest: the digest lands alone in the second beat
    seen_q.delete();
    send_tlp(3'b011, 4, 1'b1, 99, -1);
    idle(4);
    check("t2_beats", 272'(seen_q.size()), 272'(2));
    if (seen_q.size() == 2) begin
      check("t2_b1", 272'({seen_q[0].dw, seen_q[0].len, seen_q[0].en, seen_q[0].last}), 272'({4'd8, 3'd7, 1'b1, 1'b0}));
      check("t2_b2", 272'({seen_q[1].dw, seen_q[1].len, seen_q[1].en, seen_q[1].done, seen_q[1].last}),
            272'({4'd0, 3'd0, 1'b0, 1'b1, 1'b1}));
    end

    // 3DW MWr Len=1024 without digest: 1027 DWs
    seen_q.delete();
    send_tlp(3'b010, 0, 1'b0, 9999, -1);
    idle(4);
    en_cnt = 0; done_cnt = 0; last_cnt = 0;
    foreach (seen_q[i]) begin
      en_cnt   += int'(seen_q[i].en);
      done_cnt += int'(seen_q[i].done);
      last_cnt += int'(seen_q[i].last);
    end
    check("t3_beats", 272'(seen_q.size()), 272'(129));
    check("t3_en_none", 272'(en_cnt), 272'(0));
    check("t3_done_none", 272'(done_cnt), 272'(0));
    check("t3_single_last", 272'(last_cnt), 272'(1));
    if (seen_q.size() == 129) check("t3_last_beat", 272'({seen_q[128].dw, seen_q[128].last}), 272'({4'd3, 1'b1}));

    // 4DW Len=24 with digest (29 DWs), output stalled after the second beat
    seen_q.delete();
    send_tlp(3'b011, 24, 1'b1, 99, 1);
    idle(4);
    en_cnt = 0; done_cnt = 0;
    foreach (seen_q[i]) begin
      en_cnt   += int'(seen_q[i].en);
      done_cnt += int'(seen_q[i].done);
    end
    check("t4_beats", 272'(seen_q.size()), 272'(4));
    check("t4_en_count", 272'(en_cnt), 272'(4));
    check("t4_done_count", 272'(done_cnt), 272'(1));
    if (seen_q.size() == 4) check("t4_last", 272'({seen_q[3].dw, seen_q[3].len}), 272'({4'd4, 3'd3}));

    // New sop arrives in the middle of a TLP, then a short 3DW Len=2 TLP follows
    seen_q.delete();
    send_tlp(3'b011, 100, 1'b1, 2, -1);
    exp_malf++;
    exp_nclr_low++;
    send_tlp(3'b010, 2, 1'b1, 99, -1);
    idle(4);
    check("t5_beats", 272'(seen_q.size()), 272'(3));
    if (seen_q.size() == 3) check("t5_new_tlp", 272'({seen_q[2].dw, seen_q[2].hdr, seen_q[2].done}), 272'({4'd5, 1'b1, 1'b1}));

    // Non-sop beat while idle is dropped
    seen_q.delete();
    send_beat(1'b0, {8{32'hDEAD_BEEF}});
    exp_malf++;
    idle(4);
    check("t6_dropped", 272'(seen_q.size()), 272'(0));

    // Checking disabled, TD=1, 3DW Len=2
    chk_en = 1'b0;
    seen_q.delete();
    send_tlp(3'b010, 2, 1'b1, 99, -1);
    idle(4);
    if (seen_q.size() == 1) check("t7_chk_off", 272'({seen_q[0].dw, seen_q[0].en, seen_q[0].done}), 272'({4'd5, 1'b0, 1'b0}));
    else check("t7_beats", 272'(seen_q.size()), 272'(1));

    check("malformed_pulses", 272'(malf_cnt), 272'(exp_malf));
    check("n_clr_low_cycles", 272'(nclr_low_cnt), 272'(exp_nclr_low));

    // Reset in the middle of a TLP discards it, and the next TLP decodes normally
    chk_en = 1'b1;
    send_tlp(3'b010, 64, 1'b1, 3, -1);
    tb_armed = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    check_reset_values();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    seen_q.delete();
    send_tlp(3'b010, 4, 1'b1, 99, -1);
    idle(4);
    check("t8_beats", 272'(seen_q.size()), 272'(1));
    if (seen_q.size() == 1) check("t8_after_reset", 272'({seen_q[0].dw, seen_q[0].len, seen_q[0].done}), 272'({4'd7, 3'd6, 1'b1}));
    check("queue_drained", 272'(exp_q.size()), 272'(0));
    check("n_clr_low_final", 272'(nclr_low_cnt), 272'(exp_nclr_low));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
